mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 16, address width of the shared RAM and all requester address ports.
REQ-002 SHALL have parameter DATA_W, 8, data width of the shared RAM and all requester data ports.
REQ-003 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports vid_req/vid_addr  input  1/ADDR_W  video fetch request (read-only) and address.
REQ-006 SHALL have ports vid_ack/vid_rdata  output  1/DATA_W  video completion pulse and read data.
REQ-007 SHALL have ports cpu_req/cpu_we/cpu_addr/cpu_wdata  input  1/1/ADDR_W/DATA_W  CPU request, write enable, address, write data.
REQ-008 SHALL have ports cpu_ack/cpu_rdata/cpu_wait  output  1/DATA_W/1  CPU completion pulse, read data, stall.
REQ-009 SHALL have ports dma_req/dma_we/dma_addr/dma_wdata  input  1/1/ADDR_W/DATA_W  loader/DMA request, write enable, address, write data.
REQ-010 SHALL have ports dma_ack/dma_rdata  output  1/DATA_W  DMA completion pulse and read data.
REQ-011 SHALL have ports mem_a/mem_d/mem_we  output  ADDR_W/DATA_W/1  single-port RAM address, write data, write enable.
REQ-012 SHALL have port mem_q  input  DATA_W  RAM read data, valid one clk after mem_a is presented.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; only IDLE samples requests; no request in IDLE keeps IDLE.
REQ-014 IDLE SHALL grant vid over any other; otherwise round-robin between cpu and dma, toggling preference to the non-served one after each cpu/dma grant; reset preference = cpu.
REQ-015 IDLE SHALL mask the requester served in the immediately preceding DONE for that one IDLE cycle (requester drops req after seeing ack).
REQ-016 On grant SHALL latch winner id, addr, we (vid forced 0), wdata into registers.
REQ-017 ISSUE SHALL drive mem_a/mem_d from latched values and mem_we=latched we for exactly one cycle; mem_we SHALL be 0 in every other state.
REQ-018 mem_a/mem_d SHALL hold latched values through WAIT and DONE.
REQ-019 WAIT end SHALL capture mem_q into the winner's rdata register; other rdata registers unchanged; writes also capture mem_q (RAM read-during-write value, don't-care).
REQ-020 DONE SHALL assert exactly the winner's ack for one cycle; latency = 4 cycles from IDLE sample edge to ack cycle; back-to-back throughput one access per 4 cycles.
REQ-021 rdata outputs SHALL be registered and hold until that requester's next capture.
REQ-022 cpu_wait SHALL equal cpu_req & ~cpu_ack combinationally.
REQ-023 Request inputs changing outside IDLE SHALL not affect the in-flight access.
REQ-024 Worst-case cpu grant delay with vid idle SHALL be 8 cycles (one dma access ahead); vid continuous asserts SHALL starve cpu/dma by design.

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE, mem_we 0, all acks 0, mem_a/mem_d/rdata 0, preference cpu.
REQ-026 Reset mid-access SHALL abandon it without ack; an ISSUE write may be lost; first post-reset grant occurs in the first IDLE after reset_n rises.

Structure
REQ-027 Shared package mem_arbiter_pkg SHALL hold state enum (IDLE, ISSUE, WAIT, DONE) and requester id constants (ID_VID, ID_CPU, ID_DMA).
REQ-028 SHALL be one module with no sub-modules; arbitration is small enough inline.

Verification
REQ-029 cpu read 0x4000 (RAM holds 0xA5) alone -> mem_a=0x4000 in ISSUE, cpu_ack 4 cycles after sample, cpu_rdata=0xA5, cpu_wait high until ack.
REQ-030 dma write 0x1234<=0x5A then cpu read 0x1234 -> single mem_we pulse, cpu_rdata=0x5A.
REQ-031 vid, cpu, dma all requesting in same IDLE -> order vid, cpu, dma (vid re-requests after each ack -> vid, cpu, vid, dma).
REQ-032 cpu and dma held continuously, vid idle -> grants alternate cpu, dma, cpu, dma; no requester acked twice consecutively.
REQ-033 reset_n low during ISSUE of cpu write -> mem_we drops immediately, no cpu_ack, next IDLE grants normally.
REQ-034 vid_req with vid addr 0x5FFF while cpu in WAIT -> cpu completes first, vid granted in following IDLE, vid_rdata correct.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding and requester ids for the RAM arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   localparam logic [1:0] ID_VID = 2'd0;
   localparam logic [1:0] ID_CPU = 2'd1;
   localparam logic [1:0] ID_DMA = 2'd2;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between video, CPU and DMA requesters.
// Video has absolute priority; CPU and DMA alternate; every access takes IDLE/ISSUE/WAIT/DONE.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_wait,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q
);
   import mem_arbiter_pkg::*;

   state_t              state_q, state_d;
   logic [1:0]          id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                pref_q, pref_d;
   logic [2:0]          mask_q, mask_d;
   logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                v, c, d;

   // pref_q = 1 means DMA wins the next CPU/DMA tie; mask_q blocks the just-served requester for one IDLE
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      pref_d      = pref_q;
      mask_d      = '0;
      vid_rdata_d = vid_rdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      v           = vid_req & ~mask_q[ID_VID];
      c           = cpu_req & ~mask_q[ID_CPU];
      d           = dma_req & ~mask_q[ID_DMA];
      case (state_q)
         IDLE: if (v | c | d) begin
            state_d = ISSUE;
            id_d    = v ? ID_VID : (c & (~d | ~pref_q)) ? ID_CPU : ID_DMA;
            addr_d  = v ? vid_addr : (id_d == ID_CPU) ? cpu_addr : dma_addr;
            we_d    = ~v & ((id_d == ID_CPU) ? cpu_we : dma_we);
            wdata_d = v ? '0 : (id_d == ID_CPU) ? cpu_wdata : dma_wdata;
            pref_d  = v ? pref_q : (id_d == ID_CPU);
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            state_d     = DONE;
            vid_rdata_d = (id_q == ID_VID) ? mem_q : vid_rdata_q;
            cpu_rdata_d = (id_q == ID_CPU) ? mem_q : cpu_rdata_q;
            dma_rdata_d = (id_q == ID_DMA) ? mem_q : dma_rdata_q;
         end
         DONE: begin
            state_d = IDLE;
            mask_d  = 3'b001 << id_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         id_q        <= ID_VID;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         pref_q      <= 1'b0;
         mask_q      <= '0;
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         pref_q      <= pref_d;
         mask_q      <= mask_d;
         vid_rdata_q <= vid_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign mem_a     = addr_q;
   assign mem_d     = wdata_q;
   assign mem_we    = (state_q == ISSUE) & we_q;
   assign vid_ack   = (state_q == DONE) & (id_q == ID_VID);
   assign cpu_ack   = (state_q == DONE) & (id_q == ID_CPU);
   assign dma_ack   = (state_q == DONE) & (id_q == ID_DMA);
   assign vid_rdata = vid_rdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_wait  = cpu_req & ~cpu_ack;
endmodule
